// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: K quotient bits per cycle, MSB first.
// result = {remainder, quotient}; a zero divisor yields an all-zero result.
module divider #(
    parameter int divider_implementation = 5,
    parameter int size                   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [size-1:0]   dividend_i,
    input  logic [size-1:0]   divisor_i,
    input  logic              div_enable_i,
    output logic              division_finished_out,
    output logic [2*size-1:0] result
);
    localparam int K     = divider_implementation;
    localparam int N     = (size + K - 1) / K;
    localparam int NK    = N * K;
    localparam int CNT_W = (N > 1) ? $clog2(N + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [NK-1:0]    dvd_q, dvd_d;
    logic [size-1:0]  quo_q, quo_d;
    logic [size-1:0]  rem_q, rem_d;
    logic [size-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [size:0]    trial;
    logic             last_iter;

    assign last_iter = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_enable_i) state_d = BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The dividend is zero-extended at the top to N*K bits, so the leading
    // padding steps only shift zeros and leave remainder/quotient untouched.
    always_comb begin
        dvd_d = dvd_q;
        quo_d = quo_q;
        rem_d = rem_q;
        trial = '0;
        for (int s = 0; s < K; s++) begin
            trial = {rem_d, dvd_d[NK-1]};
            dvd_d = dvd_d << 1;
            if (trial >= {1'b0, dvs_q}) begin
                trial = trial - {1'b0, dvs_q};
                quo_d = (quo_d << 1) | size'(1);
            end else begin
                quo_d = quo_d << 1;
            end
            rem_d = trial[size-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q                 <= '0;
            quo_q                 <= '0;
            rem_q                 <= '0;
            dvs_q                 <= '0;
            cnt_q                 <= '0;
            division_finished_out <= 1'b0;
            result                <= '0;
        end else begin
            division_finished_out <= 1'b0;
            case (state_q)
                IDLE: if (div_enable_i) begin
                    dvd_q <= NK'(dividend_i);
                    dvs_q <= divisor_i;
                    rem_q <= '0;
                    quo_q <= '0;
                    cnt_q <= CNT_W'(N);
                end
                BUSY: begin
                    dvd_q <= dvd_d;
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        division_finished_out <= 1'b1;
                        result <= (dvs_q == '0) ? '0 : {rem_d, quo_d};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: three instances (K=5, K=1, K=32), directed
// vectors plus back-to-back random pairs; a negedge monitor pops and compares.
module tb_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [2:0]  en, fin, fin_prev;
    logic [63:0] res [3];

    int checks = 0;
    int errors = 0;
    logic [63:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    divider #(.divider_implementation(5), .size(32)) dut5 (
        .clk(clk), .rst(rst), .dividend_i(a), .divisor_i(b), .div_enable_i(en[0]),
        .division_finished_out(fin[0]), .result(res[0]));
    divider #(.divider_implementation(1), .size(32)) dut1 (
        .clk(clk), .rst(rst), .dividend_i(a), .divisor_i(b), .div_enable_i(en[1]),
        .division_finished_out(fin[1]), .result(res[1]));
    divider #(.divider_implementation(32), .size(32)) dut32 (
        .clk(clk), .rst(rst), .dividend_i(a), .divisor_i(b), .div_enable_i(en[2]),
        .division_finished_out(fin[2]), .result(res[2]));

    function automatic logic [63:0] model(logic [31:0] x, logic [31:0] y);
        if (y == 0) return 64'd0;
        return {x % y, x / y};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(int i, logic [63:0] e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: every pulse must match the oldest expected entry of its unit.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fin[i] === 1'b1) begin
                logic        have;
                logic [63:0] e;
                have = 1'b0;
                e    = '0;
                case (i)
                    0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                    1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                    default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
                endcase
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_pulse unit %0d: got result %h expected no pulse", i, res[i]);
                end else begin
                    chk($sformatf("result_u%0d", i), res[i], e);
                end
                if (fin_prev[i]) chk($sformatf("double_pulse_u%0d", i), 64'd1, 64'd0);
            end
        end
        fin_prev <= fin;
    end

    task automatic start(int i, logic [31:0] x, logic [31:0] y, logic [63:0] e);
        a = x; b = y; en[i] = 1'b1;
        @(posedge clk); #1;
        en[i] = 1'b0;
        push(i, e);
    endtask

    // Counts edges from the start edge to the pulse; optionally checks that
    // result holds its previous value while the unit is busy.
    task automatic wait_pulse(int i, int budget, bit hold, output int lat);
        logic [63:0] prev;
        prev = res[i];
        lat  = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (hold && fin[i] !== 1'b1) chk("result_hold_busy", res[i], prev);
        end while (fin[i] !== 1'b1 && lat < budget);
        if (fin[i] !== 1'b1) chk($sformatf("timeout_u%0d", i), {63'd0, fin[i]}, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] x, y;
        rst = 1'b1; en = '0; a = '0; b = '0; fin_prev = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_fin_u%0d", i), {63'd0, fin[i]}, 64'd0);
            chk($sformatf("reset_result_u%0d", i), res[i], 64'd0);
        end

        // Start requested during reset: only the edge after release starts.
        a = 1; b = 1; en[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, {32'd0, 32'd1});
        @(posedge clk); #1;
        en[0] = 1'b0;
        wait_pulse(0, 20, 1'b0, lat);
        chk("latency_after_reset", 64'(lat), 64'd7);
        @(posedge clk); #1;

        // 100/7 latency and result hold on each unit.
        start(0, 100, 7, {32'd2, 32'd14});
        wait_pulse(0, 20, 1'b1, lat);
        chk("latency_k5", 64'(lat), 64'd7);
        @(posedge clk); #1;
        start(1, 100, 7, {32'd2, 32'd14});
        wait_pulse(1, 40, 1'b1, lat);
        chk("latency_k1", 64'(lat), 64'd32);
        @(posedge clk); #1;
        start(2, 100, 7, {32'd2, 32'd14});
        wait_pulse(2, 10, 1'b1, lat);
        chk("latency_k32", 64'(lat), 64'd1);
        @(posedge clk); #1;

        // Edge operands and divide by zero.
        start(0, 32'hFFFF_FFFF, 1, {32'd0, 32'hFFFF_FFFF});
        wait_pulse(0, 20, 1'b0, lat); @(posedge clk); #1;
        start(0, 5, 10, {32'd5, 32'd0});
        wait_pulse(0, 20, 1'b0, lat); @(posedge clk); #1;
        start(0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
        wait_pulse(0, 20, 1'b0, lat); @(posedge clk); #1;
        start(0, 1234, 0, 64'd0);
        wait_pulse(0, 20, 1'b0, lat);
        chk("latency_div0", 64'(lat), 64'd7);
        @(posedge clk); #1;

        // A start request while busy is dropped.
        start(0, 1000, 3, {32'd1, 32'd333});
        repeat (2) @(posedge clk);
        #1;
        a = 9; b = 9; en[0] = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        wait_pulse(0, 20, 1'b0, lat);
        repeat (12) @(posedge clk);
        #1;
        chk("idle_after_busy_prot", {63'd0, fin[0]}, 64'd0);

        // Mid-division reset aborts with no pulse and clears result.
        a = 50; b = 5; en[0] = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("result_after_abort", res[0], 64'd0);

        // Back-to-back random pairs, restarting right after each pulse.
        for (int u = 0; u < 3; u++) begin
            for (int n = 0; n < 500; n++) begin
                x = $urandom;
                y = $urandom >> $urandom_range(0, 31);
                if (n % 50 == 7) y = 0;
                start(u, x, y, model(x, y));
                wait_pulse(u, 40, 1'b0, lat);
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/divider.md
# divider

Multi-cycle unsigned integer divider that computes quotient and remainder of two `size`-bit operands. It is used by the execution stage for DIV/REM-class operations. A one-cycle enable starts it, it iterates a fixed number of cycles, and then it reports completion with a one-cycle pulse. The parameter `divider_implementation` trades area for latency by setting how many quotient bits are retired per cycle.

## Interface
- `divider_implementation`, default 5: quotient bits resolved per clock cycle (K). Legal range is 1..`size`.
- `size`, default 32: operand width in bits.

- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `dividend_i`  in  `size`: unsigned dividend. Sampled only on the start cycle.
- `divisor_i`  in  `size`: unsigned divisor. Sampled only on the start cycle.
- `div_enable_i`  in  1: start request. Honoured only while idle.
- `division_finished_out`  out  1: registered one-cycle pulse marking a valid `result`.
- `result`  out  2×`size`: `{remainder, quotient}`, with the remainder in the upper half.

## Operation
- States:
  - IDLE: waits for a start.
  - BUSY: iterating; holds an iteration counter.
  - DONE: a single cycle in which `division_finished_out`=1.
- IDLE → BUSY when `div_enable_i`=1 at a rising edge. On that edge:
  - latch `dividend_i` and `divisor_i` into internal registers;
  - clear the partial remainder;
  - load the counter with N = ceil(`size`/K).
- BUSY iteration: each cycle performs K unrolled radix-2 restoring steps, MSB first. Each step:
  - shift the partial remainder left and bring in the next dividend bit;
  - trial-subtract the divisor;
  - if the difference is non-negative, keep it and set the quotient bit to 1; otherwise keep the shifted value and set the quotient bit to 0.
  - Internal remainder datapath is `size`+1 bits.
- Last iteration when `size` is not a multiple of K: only the remaining bits are processed, or the dividend is zero-extended to N·K bits. The result must be identical either way.
- BUSY → DONE after the N-th iteration edge. On that edge `result` is loaded and `division_finished_out` is set.
- DONE → IDLE unconditionally on the next edge. `division_finished_out` returns to 0.
- Output `result`:
  - holds its value until the next completion;
  - does not change while BUSY;
  - equals {dividend mod divisor, dividend / divisor}, unsigned.
- Divisor = 0: same latency as any other division, and `result` = 0 (quotient 0, remainder 0).
- `div_enable_i` in BUSY or DONE is ignored, with no queuing. Operand inputs may change freely after the start cycle.
- `div_enable_i` held high continuously: a new division starts on each return to IDLE.

## Timing
- Reset values: state IDLE, `division_finished_out`=0, `result`=0, internal registers 0.
- `rst` has priority over every other input. Asserting it mid-division aborts the operation with no completion pulse. The first start is accepted on the first edge after `rst` deasserts.
- Let the start edge be T:
  - iteration edges are T+1..T+N;
  - `division_finished_out`=1 and `result` is valid during the cycle after edge T+N;
  - the next start is accepted at edge T+N+2 at the earliest.
- Latency with the defaults (K=5, `size`=32): N=7, so the pulse is high during the cycle after edge T+7.
- With K=`size`: N=1.
- `division_finished_out` is never high for two consecutive cycles.

## Test plan
- Start during reset: `rst`=1 with `div_enable_i`=1 and operands 1/1, then release `rst` with enable high for one edge. Required: a single pulse with quotient=1, remainder=0.
- 100 / 7 with K=5: the pulse appears exactly 7 edges after the start edge, with quotient=14 and remainder=2. `result` is unchanged while BUSY.
- Edge operands:
  - 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0;
  - 5 / 10 → q=0, r=5;
  - 0x80000000 / 0xFFFFFFFF → q=0, r=0x80000000.
- Divide by zero: 1234 / 0 → `result`=0 with the normal latency.
- Busy protection: pulse enable with 1000/3, then pulse enable with 9/9 mid-division. Required: a single pulse with q=333, r=1, after which the unit returns to IDLE. A mid-division `rst` gives no pulse and `result`=0.
- Back-to-back: 500 random unsigned pairs. Restart on the cycle after each pulse and check every result against `/` and `%`. Repeat with K=1 (N=32) and K=32 (N=1).
